// File: rtl/prog_uart_loader_pkg.sv
// Shared constants for the programming-UART loader: FSM state codes and default start key.
package prog_uart_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LEN   = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_FLUSH = 2'd3;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  localparam logic [31:0] DEFAULT_PROG_KEY = 32'hCAFE_F00D;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte_vld per good frame.
module uart_rx_byte
  import prog_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  // [0],[1] synchronise, [2] holds the previous synchronised level for edge detection
  logic [2:0]       sync_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             vld_q, vld_d;
  logic [7:0]       data_q, data_d;
  logic             rx_s;
  logic             rx_fall;

  assign rx_s      = sync_q[1];
  assign rx_fall   = sync_q[2] & ~sync_q[1];
  assign byte_vld  = vld_q;
  assign byte_data = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      sync_q  <= {sync_q[1], sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          // A low stop bit is a framing error; the byte is silently dropped
          vld_d   = rx_s;
          data_d  = rx_s ? shift_q : data_q;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/prog_uart_loader.sv
// Program-load front end: waits for the start key on the UART, reads a 32-bit length,
// then packs payload bytes into RAM lines and strobes them into main memory.
module prog_uart_loader
  import prog_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned BLOCK_SIZE  = 128,
  parameter int unsigned RAM_DEPTH   = 8192,
  parameter logic [31:0] PROG_KEY    = DEFAULT_PROG_KEY,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         prog_rx_i,
  output logic                         wr_en_o,
  output logic [$clog2(RAM_DEPTH)-1:0] wr_addr_o,
  output logic [BLOCK_SIZE-1:0]        wr_data_o,
  output logic [BLOCK_SIZE/8-1:0]      wr_strb_o,
  output logic                         system_reset_o,
  output logic                         prog_mode_led_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned NUMS_BYTE    = BLOCK_SIZE / 8;
  localparam int unsigned ADDR_W       = $clog2(RAM_DEPTH);
  localparam int unsigned LANE_W       = $clog2(NUMS_BYTE);
  localparam int unsigned TMO_W        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUMS_BYTE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  logic       rx_vld;
  logic [7:0] rx_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .rx       (prog_rx_i),
    .byte_vld (rx_vld),
    .byte_data(rx_byte)
  );

  state_t                state_q, state_d;
  logic [31:0]           window_q, window_d;
  logic [1:0]            len_cnt_q, len_cnt_d;
  logic [31:0]           len_q, len_d;
  logic [31:0]           rem_q, rem_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] line_q, line_d;
  logic [NUMS_BYTE-1:0]  strb_q, strb_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BLOCK_SIZE-1:0] wr_data_q, wr_data_d;
  logic [NUMS_BYTE-1:0]  wr_strb_q, wr_strb_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  led_q, led_d;

  logic [BLOCK_SIZE-1:0] line_m;
  logic [NUMS_BYTE-1:0]  strb_m;
  logic [31:0]           len_full;
  logic [31:0]           window_next;

  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign wr_strb_o       = wr_strb_q;
  assign system_reset_o  = sys_rst_q;
  assign prog_mode_led_o = led_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      window_q  <= '0;
      len_cnt_q <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      lane_q    <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      strb_q    <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      sys_rst_q <= 1'b1;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      len_cnt_q <= len_cnt_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      strb_q    <= strb_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      sys_rst_q <= sys_rst_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    len_cnt_d = len_cnt_q;
    len_d     = len_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    line_d    = line_q;
    strb_d    = strb_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = '0;
    sys_rst_d = sys_rst_q;
    led_d     = led_q;

    // Current line with the incoming byte merged into its lane
    line_m = line_q;
    strb_m = strb_q;
    for (int unsigned k = 0; k < NUMS_BYTE; k++) begin
      if (lane_q == LANE_W'(k)) begin
        line_m[8*k +: 8] = rx_byte;
        strb_m[k]        = 1'b1;
      end
    end
    len_full    = {rx_byte, len_q[31:8]};
    window_next = {rx_byte, window_q[31:8]};

    case (state_q)
      ST_IDLE: begin
        if (rx_vld) begin
          window_d = window_next;
          if (window_next == PROG_KEY) begin
            state_d   = ST_LEN;
            sys_rst_d = 1'b0;
            led_d     = 1'b1;
            len_cnt_d = '0;
            tmo_d     = '0;
          end
        end
      end
      ST_LEN: begin
        if (rx_vld) begin
          tmo_d     = '0;
          len_d     = len_full;
          len_cnt_d = len_cnt_q + 1'b1;
          if (len_cnt_q == 2'd3) begin
            if (len_full == 32'd0) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_DATA;
              rem_d   = len_full;
              line_d  = '0;
              strb_d  = '0;
              lane_d  = '0;
              addr_d  = '0;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_FLUSH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_vld) begin
          tmo_d  = '0;
          rem_d  = rem_q - 32'd1;
          line_d = line_m;
          strb_d = strb_m;
          lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
          if (lane_q == LANE_LAST || rem_q == 32'd1) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = line_m;
            wr_strb_d = strb_m;
            addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            line_d    = '0;
            strb_d    = '0;
          end
          if (rem_q == 32'd1) state_d = ST_FLUSH;
        end else if (tmo_q == TMO_LAST) begin
          // Stalled sender: drop the partial line without writing it
          state_d = ST_FLUSH;
          line_d  = '0;
          strb_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        sys_rst_d = 1'b1;
        led_d     = 1'b0;
        window_d  = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_uart_loader.sv
// Directed bench for prog_uart_loader: serialises key/length/payload frames and scoreboards line writes.
module tb_prog_uart_loader;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned NB       = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TMO      = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_strb;
  logic         sys_rst;
  logic         led;

  prog_uart_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .BLOCK_SIZE (128),
    .RAM_DEPTH  (DEPTH),
    .PROG_KEY   (32'hCAFE_F00D),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .prog_rx_i      (rx),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .wr_strb_o      (wr_strb),
    .system_reset_o (sys_rst),
    .prog_mode_led_o(led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } wr_t;

  wr_t          exp_q[$];
  logic [1:0]   addr_log[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           wr_count = 0;
  logic [1:0]   last_addr = '0;
  logic [127:0] last_data = '0;
  logic [15:0]  last_strb = '0;
  logic [7:0]   pay [0:127];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] lane_mask(input logic [15:0] s);
    logic [127:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  // Model: byte i lands in line i/NB, lane i%NB; a line is written when full or at byte len-1
  task automatic push_expect(input int unsigned len, input int unsigned nsend);
    wr_t w;
    w = '0;
    for (int unsigned i = 0; i < nsend; i++) begin
      w.data[8*(i%NB) +: 8] = pay[i];
      w.strb[i%NB] = 1'b1;
      if ((i % NB) == NB - 1 || i == len - 1) begin
        w.addr = 2'((i / NB) % DEPTH);
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_key();
    send_byte(8'h0D, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hCA, 1'b1);
  endtask

  task automatic load(input int unsigned len, input int unsigned nsend);
    push_expect(len, nsend);
    send_key();
    check("sysrst_low_after_key", 128'(sys_rst), 128'(1'b0));
    check("led_on_after_key", 128'(led), 128'(1'b1));
    for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)), 1'b1);
    for (int unsigned i = 0; i < nsend; i++) send_byte(pay[i], 1'b1);
  endtask

  task automatic finish_check(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_pending_writes"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    repeat (5) @(negedge clk);
    check({name, "_sysrst_released"}, 128'(sys_rst), 128'(1'b1));
    check({name, "_led_off"}, 128'(led), 128'(1'b0));
  endtask

  // Per-cycle compare of the write port against the model queue
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en) begin
          wr_count++;
          addr_log.push_back(wr_addr);
          last_addr = wr_addr;
          last_data = wr_data;
          last_strb = wr_strb;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h strb %0h, expected no write (t=%0t)",
                     wr_addr, wr_strb, $time);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 128'(wr_addr), 128'(e.addr));
            check("wr_strb", 128'(wr_strb), 128'(e.strb));
            check("wr_data", wr_data & lane_mask(e.strb), e.data & lane_mask(e.strb));
          end
        end else begin
          check("strb_idle_zero", 128'(wr_strb), 128'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    logic [1:0] exp_addrs [0:4];
    exp_addrs[0] = 2'd0; exp_addrs[1] = 2'd1; exp_addrs[2] = 2'd2;
    exp_addrs[3] = 2'd3; exp_addrs[4] = 2'd0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", 128'(wr_en), 128'(0));
    check("rst_wr_addr", 128'(wr_addr), 128'(0));
    check("rst_wr_data", wr_data, 128'(0));
    check("rst_wr_strb", 128'(wr_strb), 128'(0));
    check("rst_sysrst", 128'(sys_rst), 128'(1'b1));
    check("rst_led", 128'(led), 128'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // One full line
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    n0 = wr_count;
    load(16, 16);
    finish_check("t1");
    check("t1_count", 128'(wr_count - n0), 128'(1));
    check("t1_addr", 128'(last_addr), 128'(0));
    check("t1_strb", 128'(last_strb), 128'(16'hFFFF));
    check("t1_data", last_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // Full line plus a 4-byte partial line
    for (int i = 0; i < 20; i++) pay[i] = 8'(i);
    addr_log.delete();
    load(20, 20);
    finish_check("t2");
    check("t2_count", 128'(addr_log.size()), 128'(2));
    check("t2_addr1", 128'(last_addr), 128'(1));
    check("t2_strb1", 128'(last_strb), 128'(16'h000F));
    check("t2_data1", 128'(last_data[31:0]), 128'(32'h13121110));

    // Junk byte ahead of the key
    send_byte(8'h11, 1'b1);
    pay[0] = 8'hA0; pay[1] = 8'hA1; pay[2] = 8'hA2; pay[3] = 8'hA3;
    load(4, 4);
    finish_check("t3");
    check("t3_strb", 128'(last_strb), 128'(16'h000F));
    check("t3_data", 128'(last_data[31:0]), 128'(32'hA3A2A1A0));

    // Key byte corrupted by a framing error: must not enter LEN
    n0 = wr_count;
    send_byte(8'h0D, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_sysrst_high", 128'(sys_rst), 128'(1'b1));
    check("t4_led_off", 128'(led), 128'(0));
    check("t4_no_write", 128'(wr_count - n0), 128'(0));

    // Key bytes inside payload are plain data
    pay[0] = 8'h0D; pay[1] = 8'hF0; pay[2] = 8'hFE; pay[3] = 8'hCA;
    pay[4] = 8'h0D; pay[5] = 8'hF0; pay[6] = 8'hFE; pay[7] = 8'hCA;
    load(8, 8);
    finish_check("t5");
    check("t5_strb", 128'(last_strb), 128'(16'h00FF));
    check("t5_data", 128'(last_data[63:0]), 128'(64'hCAFEF00D_CAFEF00D));

    // Sender stalls after 40 of 100 bytes
    for (int i = 0; i < 40; i++) pay[i] = 8'(i + 8'h40);
    n0 = wr_count;
    load(100, 40);
    check("t6_still_loading", 128'(sys_rst), 128'(1'b0));
    repeat (TMO + 50) @(negedge clk);
    finish_check("t6");
    check("t6_count", 128'(wr_count - n0), 128'(2));

    // Address wrap with a 4-line RAM
    for (int i = 0; i < 80; i++) pay[i] = 8'(i * 3);
    addr_log.delete();
    load(80, 80);
    finish_check("t7");
    check("t7_count", 128'(addr_log.size()), 128'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < addr_log.size()) check("t7_addr_seq", 128'(addr_log[k]), 128'(exp_addrs[k]));
    end

    // Asynchronous reset in the middle of DATA
    for (int i = 0; i < 20; i++) pay[i] = 8'(8'hC0 + i);
    load(32, 20);
    repeat (5) @(negedge clk);
    check("t8_pending_before_rst", 128'(exp_q.size()), 128'(0));
    check("t8_loading_before_rst", 128'(sys_rst), 128'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_wr_en", 128'(wr_en), 128'(0));
    check("t8_rst_wr_addr", 128'(wr_addr), 128'(0));
    check("t8_rst_wr_data", wr_data, 128'(0));
    check("t8_rst_wr_strb", 128'(wr_strb), 128'(0));
    check("t8_rst_sysrst", 128'(sys_rst), 128'(1'b1));
    check("t8_rst_led", 128'(led), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    pay[0] = 8'h55; pay[1] = 8'h66; pay[2] = 8'h77; pay[3] = 8'h88;
    n0 = wr_count;
    load(4, 4);
    finish_check("t8");
    check("t8_count", 128'(wr_count - n0), 128'(1));
    check("t8_restart_addr", 128'(last_addr), 128'(0));
    check("t8_data", 128'(last_data[31:0]), 128'(32'h88776655));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
